// File: rtl/mult_div_unit_if.sv
// Request/result bundle for the iterative multiply/divide unit.
// The requester drives the operation fields; the unit returns results and status.
interface mult_div_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             op;
  logic             sgn;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;
  logic             div0;

  modport master (
    output start, op, sgn, a, b,
    input  hi, lo, busy, done, div0
  );

  modport slave (
    input  start, op, sgn, a, b,
    output hi, lo, busy, done, div0
  );
endinterface

// File: rtl/mult_div_unit.sv
// Sequential multiplier/divider: one shift-add or restoring shift-subtract step per
// cycle on operand magnitudes, with sign correction applied once at the end.
module mult_div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic          clk,
  input  logic          reset,
  mult_div_unit_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    MULT = 3'd1,
    DIV  = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } stateT;

  localparam logic [CNT_W-1:0] LastIter = CNT_W'(WIDTH - 1);

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic sgnd);
    return (sgnd && v[WIDTH-1]) ? -v : v;
  endfunction

  function automatic logic [WIDTH-1:0] condNeg(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] condNegWide(input logic [2*WIDTH-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  stateT              state;
  stateT              nextState;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] work;
  logic [WIDTH-1:0]   operandB;
  logic               isDiv;
  logic               negLo;
  logic               negHi;
  logic [WIDTH-1:0]   hiReg;
  logic [WIDTH-1:0]   loReg;
  logic               busyReg;
  logic               doneReg;
  logic               div0Reg;

  logic [WIDTH:0]     mulSum;
  logic [2*WIDTH-1:0] mulNext;
  logic [WIDTH:0]     divShift;
  logic               divFits;
  logic [WIDTH-1:0]   divRem;
  logic [2*WIDTH-1:0] divNext;

  assign bus.hi   = hiReg;
  assign bus.lo   = loReg;
  assign bus.busy = busyReg;
  assign bus.done = doneReg;
  assign bus.div0 = div0Reg;

  // Next-state selection; a zero divisor skips the iteration entirely.
  always_comb begin
    nextState = state;
    case (state)
      IDLE: begin
        if (bus.start) begin
          if (bus.op) begin
            nextState = (bus.b == {WIDTH{1'b0}}) ? DONE : DIV;
          end else begin
            nextState = MULT;
          end
        end else begin
          nextState = IDLE;
        end
      end
      MULT, DIV: begin
        if (cnt == LastIter) begin
          nextState = FIX;
        end else begin
          nextState = state;
        end
      end
      FIX:     nextState = DONE;
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // One iteration step for each operation: work holds {acc, multiplier} or {rem, dividend/quotient}.
  always_comb begin
    mulSum   = {1'b0, work[2*WIDTH-1:WIDTH]} +
               (work[0] ? {1'b0, operandB} : {(WIDTH+1){1'b0}});
    mulNext  = {mulSum, work[WIDTH-1:1]};
    divShift = {work[2*WIDTH-1:WIDTH], work[WIDTH-1]};
    divFits  = (divShift >= {1'b0, operandB});
    divRem   = divShift[WIDTH-1:0] - operandB;
    divNext  = {(divFits ? divRem : divShift[WIDTH-1:0]), work[WIDTH-2:0], divFits};
  end

  // State, datapath and registered outputs; results reach hi/lo only on the FIX edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= {CNT_W{1'b0}};
      work     <= {(2*WIDTH){1'b0}};
      operandB <= {WIDTH{1'b0}};
      isDiv    <= 1'b0;
      negLo    <= 1'b0;
      negHi    <= 1'b0;
      hiReg    <= {WIDTH{1'b0}};
      loReg    <= {WIDTH{1'b0}};
      busyReg  <= 1'b0;
      doneReg  <= 1'b0;
      div0Reg  <= 1'b0;
    end else begin
      state   <= nextState;
      busyReg <= (nextState != IDLE);
      doneReg <= (nextState == DONE);
      div0Reg <= (state == IDLE) && (nextState == DONE);
      case (state)
        IDLE: begin
          if (bus.start) begin
            cnt      <= {CNT_W{1'b0}};
            isDiv    <= bus.op;
            operandB <= magnitude(bus.b, bus.sgn);
            work     <= {{WIDTH{1'b0}}, magnitude(bus.a, bus.sgn)};
            // Quotient/product sign from both operands; remainder follows the dividend.
            negLo    <= bus.sgn & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
            negHi    <= bus.op & bus.sgn & bus.a[WIDTH-1];
          end
        end
        MULT: begin
          work <= mulNext;
          cnt  <= cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
        DIV: begin
          work <= divNext;
          cnt  <= cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
        FIX: begin
          if (isDiv) begin
            hiReg <= condNeg(work[2*WIDTH-1:WIDTH], negHi);
            loReg <= condNeg(work[WIDTH-1:0], negLo);
          end else begin
            {hiReg, loReg} <= condNegWide(work, negLo);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed cases plus randomized operations
// compared against plain 64-bit arithmetic.
module tb_mult_div_unit;
  localparam int W   = 32;
  localparam int LAT = W + 2;

  logic clk;
  logic reset;
  int   testCnt;
  int   failCnt;
  logic [W-1:0] modelHi;
  logic [W-1:0] modelLo;

  mult_div_unit_if #(.WIDTH(W)) bus ();

  mult_div_unit #(.WIDTH(W), .CNT_W(6)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    testCnt++;
    assert (obs === exp) else begin
      failCnt++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: exact 64-bit arithmetic; division truncates toward zero in SV.
  task automatic model(input logic o, input logic s, input logic [W-1:0] av, input logic [W-1:0] bv,
                       output logic [W-1:0] eh, output logic [W-1:0] el,
                       output logic ed, output int lat);
    longint sa, sb, q, r;
    logic [63:0] ua, ub, p;
    sa = s ? longint'($signed(av)) : longint'({32'h0, av});
    sb = s ? longint'($signed(bv)) : longint'({32'h0, bv});
    ua = {32'h0, av};
    ub = {32'h0, bv};
    ed = 1'b0;
    lat = LAT;
    if (o && bv == 32'h0) begin
      eh = modelHi; el = modelLo; ed = 1'b1; lat = 1;
    end else if (!o) begin
      p = s ? 64'(sa * sb) : ua * ub;
      eh = p[63:32]; el = p[31:0];
    end else begin
      if (s) begin
        q = sa / sb; r = sa % sb;
      end else begin
        q = longint'(ua / ub); r = longint'(ua % ub);
      end
      el = q[31:0]; eh = r[31:0];
    end
  endtask

  task automatic runOp(input string tag, input logic o, input logic s,
                       input logic [W-1:0] av, input logic [W-1:0] bv,
                       input int pulseAt, input bit startInDone);
    logic [W-1:0] eh, el;
    logic ed;
    int lat, edges;
    bit busyOk, holdOk, quietOk;
    model(o, s, av, bv, eh, el, ed, lat);
    bus.start = 1'b1; bus.op = o; bus.sgn = s; bus.a = av; bus.b = bv;
    tick();
    bus.start = 1'b0;
    bus.op = 1'($urandom); bus.sgn = 1'($urandom); bus.a = $urandom; bus.b = $urandom;
    edges = 1; busyOk = 1'b1; holdOk = 1'b1;
    while (bus.done !== 1'b1 && edges < 100) begin
      if (bus.busy !== 1'b1) busyOk = 1'b0;
      if (bus.hi !== modelHi || bus.lo !== modelLo) holdOk = 1'b0;
      bus.start = (edges == pulseAt) ? 1'b1 : 1'b0;
      tick();
      edges++;
    end
    bus.start = 1'b0;
    check({tag, " latency"}, 64'(edges), 64'(lat));
    check({tag, " busy during op"}, {63'h0, busyOk}, 64'h1);
    check({tag, " hi/lo hold"}, {63'h0, holdOk}, 64'h1);
    check({tag, " done"}, {63'h0, bus.done}, 64'h1);
    check({tag, " hi"}, 64'(bus.hi), 64'(eh));
    check({tag, " lo"}, 64'(bus.lo), 64'(el));
    check({tag, " div0"}, {63'h0, bus.div0}, {63'h0, ed});
    modelHi = eh; modelLo = el;
    if (startInDone) begin
      bus.start = 1'b1; bus.op = 1'b0; bus.a = 32'h5; bus.b = 32'h6;
    end
    tick();
    bus.start = 1'b0;
    check({tag, " done pulse width"}, {63'h0, bus.done}, 64'h0);
    check({tag, " idle busy"}, {63'h0, bus.busy}, 64'h0);
    check({tag, " div0 low"}, {63'h0, bus.div0}, 64'h0);
    if (pulseAt > 0 || startInDone) begin
      quietOk = 1'b1;
      for (int i = 0; i < LAT + 4; i++) begin
        tick();
        if (bus.done !== 1'b0 || bus.busy !== 1'b0) quietOk = 1'b0;
      end
      check({tag, " no extra op"}, {63'h0, quietOk}, 64'h1);
    end
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    logic [2:0] pick;
    bit quiet;
    testCnt = 0; failCnt = 0;
    modelHi = '0; modelLo = '0;
    bus.start = 1'b0; bus.op = 1'b0; bus.sgn = 1'b0; bus.a = '0; bus.b = '0;
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    check("reset hi", 64'(bus.hi), 64'h0);
    check("reset lo", 64'(bus.lo), 64'h0);
    check("reset busy", {63'h0, bus.busy}, 64'h0);
    check("reset done", {63'h0, bus.done}, 64'h0);
    check("reset div0", {63'h0, bus.div0}, 64'h0);

    runOp("smul", 1'b0, 1'b1, 32'hFFFFFFFD, 32'h00000005, 0, 1'b0);
    check("smul const", {modelHi, modelLo}, 64'hFFFFFFFF_FFFFFFF1);
    runOp("umul", 1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 1'b0);
    check("umul const", {modelHi, modelLo}, 64'hFFFFFFFE_00000001);
    runOp("sdiv", 1'b1, 1'b1, 32'hFFFFFFF9, 32'h00000002, 0, 1'b0);
    check("sdiv const", {modelHi, modelLo}, 64'hFFFFFFFF_FFFFFFFD);
    runOp("sdiv ovf", 1'b1, 1'b1, 32'h80000000, 32'hFFFFFFFF, 0, 1'b0);
    check("sdiv ovf const", {modelHi, modelLo}, 64'h00000000_80000000);
    runOp("preload", 1'b1, 1'b0, 32'h00000451, 32'h00000020, 0, 1'b0);
    check("preload const", {modelHi, modelLo}, 64'h00000011_00000022);
    runOp("div0", 1'b1, 1'b1, 32'h12345678, 32'h00000000, 0, 1'b0);
    runOp("lockout", 1'b0, 1'b0, 32'h00001234, 32'h00005678, 5, 1'b0);
    runOp("start in done", 1'b1, 1'b0, 32'h0000ABCD, 32'h00000013, 0, 1'b1);

    // Abort a divide on its tenth iteration.
    bus.start = 1'b1; bus.op = 1'b1; bus.sgn = 1'b1; bus.a = 32'h87654321; bus.b = 32'h00000123;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    modelHi = '0; modelLo = '0;
    check("abort busy", {63'h0, bus.busy}, 64'h0);
    check("abort hi", 64'(bus.hi), 64'h0);
    check("abort lo", 64'(bus.lo), 64'h0);
    quiet = 1'b1;
    for (int i = 0; i < LAT + 4; i++) begin
      if (bus.done !== 1'b0) quiet = 1'b0;
      tick();
    end
    check("abort no done", {63'h0, quiet}, 64'h1);
    runOp("udiv after abort", 1'b1, 1'b0, 32'h00000064, 32'h00000007, 0, 1'b0);
    check("udiv const", {modelHi, modelLo}, 64'h00000002_0000000E);

    for (int n = 0; n < 24; n++) begin
      ra = $urandom; rb = $urandom;
      pick = 3'($urandom_range(0, 7));
      if (pick == 3'd0) rb = 32'h0;
      if (pick == 3'd1) ra = 32'h80000000;
      if (pick == 3'd2) rb = 32'hFFFFFFFF;
      if (pick == 3'd3) rb = 32'($urandom_range(1, 15));
      runOp("rand", 1'($urandom), 1'($urandom), ra, rb, 0, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", testCnt, failCnt);
    $finish;
  end
endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 The block SHALL take parameter WIDTH, default 32, as the operand width in bits; legal values are 8 to 64.
REQ-002 The block SHALL take parameter CNT_W, default 6, as the iteration counter width; it SHALL satisfy 2**CNT_W > WIDTH.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  operation request, sampled only in IDLE.
REQ-006 op  input  1  0 = multiply, 1 = divide.
REQ-007 sgn  input  1  1 = two's-complement operands, 0 = unsigned.
REQ-008 a  input  WIDTH  multiplicand or dividend.
REQ-009 b  input  WIDTH  multiplier or divisor.
REQ-010 hi  output  WIDTH  product upper half, or remainder.
REQ-011 lo  output  WIDTH  product lower half, or quotient.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 done  output  1  single-cycle completion pulse.
REQ-014 div0  output  1  divide-by-zero flag, valid while done=1.

Function
REQ-015 The block SHALL implement states IDLE, MULT, DIV, FIX and DONE.
REQ-016 In IDLE with start=1, the block SHALL latch op, sgn, a and b, clear the counter, and go to MULT (op=0) or DIV (op=1).
REQ-017 In IDLE with start=1, op=1 and b=0, the block SHALL go directly to DONE with div0=1 and SHALL leave hi and lo unchanged.
REQ-018 When sgn=1, the block SHALL iterate on operand magnitudes and record the result signs at latch time.
REQ-019 MULT SHALL perform one shift-add step per cycle for exactly WIDTH cycles, then go to FIX.
REQ-020 DIV SHALL perform one restoring shift-subtract step per cycle for exactly WIDTH cycles, then go to FIX.
REQ-021 FIX SHALL apply sign correction, write hi and lo on the same edge, and go to DONE.
REQ-022 The multiply result SHALL be the full 2*WIDTH-bit product, with {hi,lo} = a*b.
REQ-023 Division SHALL give lo = quotient truncated toward zero and hi = remainder carrying the sign of the dividend.
REQ-024 Signed divide of the most negative value by -1 SHALL return lo = the most negative value and hi = 0, with no flag.
REQ-025 In DONE, done SHALL be 1 for exactly one cycle, and the next state SHALL be IDLE unconditionally.
REQ-026 Latency SHALL be WIDTH+2 edges from the start-accepting edge to the edge that asserts done: 1 latch edge, WIDTH iteration edges, 1 FIX edge.
REQ-027 For divide-by-zero, done SHALL assert one edge after the start-accepting edge.
REQ-028 div0 SHALL be 0 whenever done=0, and 0 on every done pulse other than divide-by-zero.
REQ-029 start SHALL be ignored while busy=1; inputs a, b, op and sgn SHALL not affect an operation in progress.
REQ-030 start asserted in the DONE cycle SHALL be ignored; a new operation is accepted in IDLE on the following cycle.
REQ-031 hi and lo SHALL hold their last written values until the next FIX or reset, and SHALL not change during iteration.
REQ-032 Internal partial results SHALL not be visible on hi or lo.

Reset
REQ-033 With reset=1 at a rising edge, the block SHALL set state to IDLE and hi, lo, busy, done, div0 and the counter to 0.
REQ-034 Reset SHALL take priority over start and over any in-progress operation; an aborted operation SHALL produce no done pulse.
REQ-035 Reset SHALL be asserted for at least one edge at power-up.

Verification (WIDTH=32)
REQ-036 Signed multiply: op=0, sgn=1, a=FFFFFFFD (-3), b=00000005 -> done 34 edges after start, hi=FFFFFFFF, lo=FFFFFFF1, div0=0.
REQ-037 Unsigned multiply: op=0, sgn=0, a=b=FFFFFFFF -> hi=FFFFFFFE, lo=00000001.
REQ-038 Signed divide: op=1, sgn=1, a=FFFFFFF9 (-7), b=00000002 -> lo=FFFFFFFD, hi=FFFFFFFF; repeat with a=80000000, b=FFFFFFFF -> lo=80000000, hi=00000000.
REQ-039 Divide by zero: hi/lo preloaded with 00000011/00000022, then op=1, b=0 -> done and div0=1 one edge after start, hi/lo unchanged.
REQ-040 Busy lockout: start pulsed on cycle 5 of a multiply with different operands -> the original result is returned, exactly one done pulse, busy=1 throughout.
REQ-041 Reset mid-operation: reset on iteration 10 of a divide -> next cycle busy=0, hi=lo=0, no done pulse; a new unsigned divide 00000064/00000007 -> lo=0000000E, hi=00000002.
